gmii_tx_sched: RTL and testbench
================================

GMII_TX_SCHED -- requirements
Module: gmii_tx_sched

Interface
REQ-001 Parameter: IFG_LEN, default 12, meaning idle cycles (tx_en=0) forced after every frame; legal range 1..255.
REQ-002 Port: clk  input  1  transmit clock; all logic on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Ports: p0_srdy / p1_srdy  input  1 each  requester byte valid.
REQ-005 Ports: p0_drdy / p1_drdy  output  1 each  byte accepted.
REQ-006 Ports: p0_data / p1_data  input  8 each  frame byte, DA first, no preamble.
REQ-007 Ports: p0_eop / p1_eop  input  1 each  marks last byte of frame.
REQ-008 Port: txd  output  8  GMII transmit data.
REQ-009 Port: tx_en  output  1  GMII transmit enable.
REQ-010 Port: tx_er  output  1  GMII transmit error.
REQ-011 Port: grant  output  1  index of port owning the current or most recent frame.
REQ-012 Port: underrun  output  1  one-cycle pulse on frame abort.

Function
REQ-013 Transfer on port n occurs in a cycle where pn_srdy=1 and pn_drdy=1.
- pn_drdy=1 only in DATA state with grant=n.
- The other port's drdy=0 (except ABORT, see REQ-019).
REQ-014 States: IDLE, PRE, SFD, DATA, CRC, ABORT, IFG; one-hot or encoded at implementer's choice.
REQ-015 IDLE: when any pn_srdy=1, latch grant and go to PRE.
- Single requester: that port wins.
- Both requesting: round-robin; port other than the last granted wins; first grant after reset goes to port 0.
REQ-016 PRE: exactly 7 cycles, txd=8'h55, tx_en=1; then SFD.
REQ-017 SFD: 1 cycle, txd=8'hD5, tx_en=1; then DATA.
REQ-018 DATA: each transferred byte appears on txd with tx_en=1 exactly one cycle after its transfer (registered outputs).
- Transfer with eop=1: go to CRC if enabled (REQ-026), else IFG.
REQ-019 Underrun: in DATA, granted pn_srdy=0 is an underrun.
- Next cycle: tx_en=1, tx_er=1, txd=8'h00, underrun=1 for one cycle.
- Then ABORT.
REQ-020 ABORT: tx_en=0, tx_er=0; granted pn_drdy=1, discarding bytes until an eop transfer; then IFG.
REQ-021 IFG: tx_en=0, txd=8'h00 for IFG_LEN cycles counted by an 8-bit down-counter; then IDLE.
- Arbitration happens only in IDLE; no requester is granted during IFG.
REQ-022 Requester srdy/data/eop changes outside DATA/ABORT of its own grant have no effect.
REQ-023 Single-byte frame (eop on first transfer) is legal; no minimum-length padding is performed.

Reset
REQ-024 Reset asserted (any time, including mid-frame) forces state=IDLE within the same cycle.
- Outputs: txd=8'h00, tx_en=0, tx_er=0, underrun=0, grant=0, p0_drdy=0, p1_drdy=0.
- Round-robin pointer selects port 0; IFG counter=0; CRC register=32'hFFFFFFFF.
REQ-025 After reset deassertion, first frame starts no earlier than the first rising edge with a requester srdy=1.

Configuration
REQ-026 Macro GMII_TX_CRC_EN:
- Defined: CRC-32 (poly 32'h04C11DB7, init 32'hFFFFFFFF, LSB-first per byte, result bit-reflected and complemented) is accumulated over all DATA bytes.
- Defined: CRC state emits 4 FCS bytes, least-significant byte of the final FCS first, tx_en=1, then IFG.
- Defined: CRC register reinitialised at SFD.
- Not defined: no CRC state and no CRC logic; requester bytes are expected to contain FCS; eop goes directly to IFG.

Verification
REQ-027 Port 0 sends 64-byte frame, port 1 idle -> tx_en high 7x 55, D5, 64 bytes in order (plus 4 FCS with GMII_TX_CRC_EN; FCS matches software CRC-32, residue check 32'hC704DD7B); then exactly 12 cycles tx_en=0.
REQ-028 Both ports assert srdy simultaneously, each with three 60-byte frames -> grant sequence 0,1,0,1,0,1; each frame separated by 12 idle cycles.
REQ-029 Port 1 drops srdy after byte 20 of 100 -> cycle with tx_en=1, tx_er=1, underrun=1; remaining bytes drained with tx_en=0; IFG; next frame is clean.
REQ-030 Reset asserted during byte 30 of DATA -> same-cycle tx_en=0, both drdy=0; after release a new frame from port 1 starts with full preamble and grant=1.
REQ-031 IFG_LEN=1, back-to-back 1-byte frames on port 0 -> 9 cycles (13 with CRC) tx_en=1, 1 cycle tx_en=0, repeat.

Source files
------------

// File: rtl/gmii_tx_sched.sv
// gmii_tx_sched: two-port GMII transmit scheduler.
// Arbitrates between two byte-stream requesters and frames each packet as
// 7 x 8'h55 preamble, 8'hD5 SFD, payload, optional FCS, then a fixed
// inter-frame gap of IFG_LEN idle cycles.
// Optional feature: define GMII_TX_CRC_EN to append a CRC-32 FCS in hardware.
// Without it, requesters supply the FCS themselves.
//
// Outputs are registered, and each state launches the line symbol for the
// following cycle. The IDLE->PRE transition therefore launches the first
// preamble byte, PRE lasts 6 cycles for the remaining six, and SFD launches
// 8'hD5. The result is that 8'hD5 is on the line during the first DATA
// cycle, in the same cycle as the first byte transfer.
//
// state | meaning
// IDLE  | line idle, arbitrate on any srdy
// PRE   | launching preamble bytes 2..7
// SFD   | launching start-of-frame delimiter
// DATA  | accepting granted bytes, forwarding one cycle later
// CRC   | launching 4 FCS bytes (GMII_TX_CRC_EN only)
// ABORT | draining granted requester to eop after an underrun
// IFG   | IFG_LEN forced idle cycles
module gmii_tx_sched #(
   parameter int IFG_LEN = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       p0_srdy,
   output logic       p0_drdy,
   input  logic [7:0] p0_data,
   input  logic       p0_eop,
   input  logic       p1_srdy,
   output logic       p1_drdy,
   input  logic [7:0] p1_data,
   input  logic       p1_eop,
   output logic [7:0] txd,
   output logic       tx_en,
   output logic       tx_er,
   output logic       grant,
   output logic       underrun
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_DATA,
`ifdef GMII_TX_CRC_EN
      ST_CRC,
`endif
      ST_ABORT,
      ST_IFG
   } state_t;

   localparam logic [7:0] IFG_LOAD = 8'(IFG_LEN - 1);
   localparam logic [7:0] PRE_LOAD = 8'd5;

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_rr;
   logic       r_grant;
   logic [7:0] r_txd;
   logic       r_tx_en;
   logic       r_tx_er;
   logic       r_underrun;

   logic       w_srdy;
   logic [7:0] w_data;
   logic       w_eop;
   logic       w_pick;
   logic       w_xfer;

   assign w_srdy = r_grant ? p1_srdy : p0_srdy;
   assign w_data = r_grant ? p1_data : p0_data;
   assign w_eop  = r_grant ? p1_eop  : p0_eop;
   // r_rr holds the port favoured on a tie: the one not granted last time.
   assign w_pick = (p0_srdy && p1_srdy) ? r_rr : p1_srdy;
   assign w_xfer = (r_state == ST_DATA) || (r_state == ST_ABORT);

   assign p0_drdy  = w_xfer && !r_grant;
   assign p1_drdy  = w_xfer &&  r_grant;
   assign grant    = r_grant;
   assign txd      = r_txd;
   assign tx_en    = r_tx_en;
   assign tx_er    = r_tx_er;
   assign underrun = r_underrun;

`ifdef GMII_TX_CRC_EN
   logic [31:0] r_crc;
   logic [31:0] w_fcs;
   logic [7:0]  w_fcs_byte;

   // Reflected CRC-32 step; 32'hEDB88320 is 32'h04C11DB7 bit-reversed,
   // which makes the LSB-first byte ordering fall out naturally.
   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] v;
      v = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      return v;
   endfunction

   assign w_fcs = ~r_crc;

   // Select the FCS byte for the current CRC beat; r_cnt counts 3 down to 0.
   always_comb begin
      w_fcs_byte = 8'h00;
      case (r_cnt[1:0])
         2'd3:    w_fcs_byte = w_fcs[7:0];
         2'd2:    w_fcs_byte = w_fcs[15:8];
         2'd1:    w_fcs_byte = w_fcs[23:16];
         default: w_fcs_byte = w_fcs[31:24];
      endcase
   end

   // Accumulate CRC over accepted payload bytes, restarting at every SFD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_crc <= 32'hFFFFFFFF;
      else if (r_state == ST_SFD)
         r_crc <= 32'hFFFFFFFF;
      else if (r_state == ST_DATA && w_srdy)
         r_crc <= crc_next(r_crc, w_data);
   end
`endif

   // Main sequencer: state, arbitration, timers and registered line outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 8'd0;
         r_rr       <= 1'b0;
         r_grant    <= 1'b0;
         r_txd      <= 8'h00;
         r_tx_en    <= 1'b0;
         r_tx_er    <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_tx_er    <= 1'b0;
         r_underrun <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (p0_srdy || p1_srdy) begin
                  r_grant <= w_pick;
                  r_rr    <= !w_pick;
                  r_cnt   <= PRE_LOAD;
                  r_txd   <= 8'h55;
                  r_tx_en <= 1'b1;
                  r_state <= ST_PRE;
               end else begin
                  r_txd   <= 8'h00;
                  r_tx_en <= 1'b0;
               end
            end
            ST_PRE: begin
               r_txd   <= 8'h55;
               r_tx_en <= 1'b1;
               if (r_cnt == 8'd0)
                  r_state <= ST_SFD;
               else
                  r_cnt <= r_cnt - 8'd1;
            end
            ST_SFD: begin
               r_txd   <= 8'hD5;
               r_tx_en <= 1'b1;
               r_state <= ST_DATA;
            end
            ST_DATA: begin
               r_tx_en <= 1'b1;
               if (w_srdy) begin
                  r_txd <= w_data;
                  if (w_eop) begin
`ifdef GMII_TX_CRC_EN
                     r_cnt   <= 8'd3;
                     r_state <= ST_CRC;
`else
                     r_cnt   <= IFG_LOAD;
                     r_state <= ST_IFG;
`endif
                  end
               end else begin
                  r_txd      <= 8'h00;
                  r_tx_er    <= 1'b1;
                  r_underrun <= 1'b1;
                  r_state    <= ST_ABORT;
               end
            end
`ifdef GMII_TX_CRC_EN
            ST_CRC: begin
               r_txd   <= w_fcs_byte;
               r_tx_en <= 1'b1;
               if (r_cnt == 8'd0) begin
                  r_cnt   <= IFG_LOAD;
                  r_state <= ST_IFG;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
`endif
            ST_ABORT: begin
               r_txd   <= 8'h00;
               r_tx_en <= 1'b0;
               if (w_srdy && w_eop) begin
                  r_cnt   <= IFG_LOAD;
                  r_state <= ST_IFG;
               end
            end
            ST_IFG: begin
               r_txd   <= 8'h00;
               r_tx_en <= 1'b0;
               if (r_cnt == 8'd0)
                  r_state <= ST_IDLE;
               else
                  r_cnt <= r_cnt - 8'd1;
            end
            default: begin
               r_txd   <= 8'h00;
               r_tx_en <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed bench for gmii_tx_sched: single frame, round-robin, underrun,
// mid-frame reset, and minimum-IFG back-to-back frames on a second instance.
module tb_gmii_tx_sched;

`ifdef GMII_TX_CRC_EN
   localparam int FCS = 4;
`else
   localparam int FCS = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       p0_srdy, p0_eop, p1_srdy, p1_eop;
   logic [7:0] p0_data, p1_data;
   wire        p0_drdy, p1_drdy, tx_en, tx_er, grant, underrun;
   wire  [7:0] txd;

   logic       q0_srdy, q0_eop, q1_srdy, q1_eop;
   logic [7:0] q0_data, q1_data;
   wire        q0_drdy, q1_drdy, q_tx_en, q_tx_er, q_grant, q_underrun;
   wire  [7:0] q_txd;

   gmii_tx_sched dut (
      .clk(clk), .reset(reset),
      .p0_srdy(p0_srdy), .p0_drdy(p0_drdy), .p0_data(p0_data), .p0_eop(p0_eop),
      .p1_srdy(p1_srdy), .p1_drdy(p1_drdy), .p1_data(p1_data), .p1_eop(p1_eop),
      .txd(txd), .tx_en(tx_en), .tx_er(tx_er), .grant(grant), .underrun(underrun)
   );

   gmii_tx_sched #(.IFG_LEN(1)) dut1 (
      .clk(clk), .reset(reset),
      .p0_srdy(q0_srdy), .p0_drdy(q0_drdy), .p0_data(q0_data), .p0_eop(q0_eop),
      .p1_srdy(q1_srdy), .p1_drdy(q1_drdy), .p1_data(q1_data), .p1_eop(q1_eop),
      .txd(q_txd), .tx_en(q_tx_en), .tx_er(q_tx_er), .grant(q_grant), .underrun(q_underrun)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] v;
      v = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      return v;
   endfunction

   // line monitor for the main instance
   logic [8:0] mb[$];
   int fr_start[$], fr_len[$], fr_gap[$], fr_grant[$];
   bit in_fr = 0;
   int gap_run = 0;
   int n_und = 0, n_er = 0;

   always @(negedge clk) begin
      if (tx_en) begin
         if (!in_fr) begin
            fr_start.push_back(mb.size());
            fr_len.push_back(0);
            fr_gap.push_back(gap_run);
            fr_grant.push_back(int'(grant));
            in_fr = 1;
         end
         mb.push_back({tx_er, txd});
         fr_len[fr_len.size()-1] += 1;
         gap_run = 0;
      end else begin
         in_fr = 0;
         gap_run++;
      end
      if (underrun) n_und++;
      if (tx_er) n_er++;
   end

   // tx_en trace of the IFG_LEN=1 instance
   bit e_on = 0;
   bit en_q[$];
   always @(negedge clk) if (e_on) en_q.push_back(q_tx_en);

   int  drv_cnt[2];
   bit  drv_kill = 0;

   task automatic set_port(input int p, input logic s, input logic [7:0] d, input logic e);
      if (p == 0) begin p0_srdy = s; p0_data = d; p0_eop = e; end
      else        begin p1_srdy = s; p1_data = d; p1_eop = e; end
   endtask

   // Byte k of a frame is seed+k; drop_at>=0 withholds srdy for one cycle there.
   task automatic drive_frame(input int p, input int len, input logic [7:0] seed, input int drop_at);
      int k, guard;
      bit dropped, got;
      k = 0; guard = 0; dropped = 0;
      drv_cnt[p] = 0;
      while (k < len && !drv_kill && guard < 4000) begin
         got = 0;
         if (k == drop_at && !dropped) begin
            set_port(p, 1'b0, 8'h00, 1'b0);
            dropped = 1;
         end else begin
            set_port(p, 1'b1, seed + 8'(k), k == len - 1);
            @(negedge clk);
            got = (p == 0) ? p0_drdy : p1_drdy;
         end
         @(posedge clk);
         #1;
         if (got) begin k++; drv_cnt[p] = k; end
         guard++;
      end
      set_port(p, 1'b0, 8'h00, 1'b0);
      if (!drv_kill) chk($sformatf("drv%0d_done", p), k, len);
   endtask

   task automatic wait_frames(input string tag, input int n, input int budget);
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         #1;
         if (fr_len.size() >= n && !in_fr) break;
      end
      chk({tag, "_done"}, 32'(fr_len.size() >= n && !in_fr), 1);
   endtask

   task automatic check_frame(input string tag, input int idx, input int gnt,
                              input logic [7:0] seed, input int len);
      int nbad;
      logic [8:0] e;
      logic [31:0] c, fcs;
      if (idx >= fr_len.size()) begin
         chk({tag, "_present"}, 0, 1);
         return;
      end
      chk({tag, "_len"}, fr_len[idx], 8 + len + FCS);
      chk({tag, "_grant"}, fr_grant[idx], gnt);
      nbad = 0;
      c = 32'hFFFFFFFF;
      fcs = 0;
      for (int i = 0; i < 8 + len + FCS && i < fr_len[idx]; i++) begin
         if (i < 7)            e = {1'b0, 8'h55};
         else if (i == 7)      e = {1'b0, 8'hD5};
         else if (i < 8 + len) begin
            e = {1'b0, seed + 8'(i - 8)};
            c = crc_upd(c, e[7:0]);
            fcs = ~c;
         end else              e = {1'b0, fcs[8*(i-8-len) +: 8]};
         if (mb[fr_start[idx] + i] !== e) nbad++;
      end
      chk({tag, "_bytes"}, nbad, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base, nbad, und0, er0, run;
      bit cur;
      int hi[$], lo[$];
      logic [31:0] c, rev;

      set_port(0, 1'b0, 8'h00, 1'b0);
      set_port(1, 1'b0, 8'h00, 1'b0);
      q0_srdy = 0; q0_data = 0; q0_eop = 0;
      q1_srdy = 0; q1_data = 0; q1_eop = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_txd", txd, 0);
      chk("rst_tx_er", tx_er, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_grant", grant, 0);
      chk("rst_p0_drdy", p0_drdy, 0);
      chk("rst_p1_drdy", p1_drdy, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_tx_en", tx_en, 0);

      // single 64-byte frame on port 0, then a short one to measure the IFG
      base = fr_len.size();
      drive_frame(0, 64, 8'h10, -1);
      drive_frame(0, 4, 8'h90, -1);
      wait_frames("a", base + 2, 300);
      check_frame("a0", base, 0, 8'h10, 64);
      check_frame("a1", base + 1, 0, 8'h90, 4);
      chk("a_ifg", fr_gap[base + 1], 12);
`ifdef GMII_TX_CRC_EN
      c = 32'hFFFFFFFF;
      for (int i = 8; i < 8 + 64 + 4; i++) c = crc_upd(c, mb[fr_start[base] + i][7:0]);
      for (int i = 0; i < 32; i++) rev[i] = c[31 - i];
      chk("a_residue", rev, 32'hC704DD7B);
`endif

      // both ports, three 60-byte frames each: strict alternation from port 0
      do_reset();
      base = fr_len.size();
      fork
         begin
            drive_frame(0, 60, 8'h20, -1);
            drive_frame(0, 60, 8'h40, -1);
            drive_frame(0, 60, 8'h60, -1);
         end
         begin
            drive_frame(1, 60, 8'hA0, -1);
            drive_frame(1, 60, 8'hC0, -1);
            drive_frame(1, 60, 8'hE0, -1);
         end
      join
      wait_frames("b", base + 6, 300);
      for (int j = 0; j < 6; j++) begin
         check_frame($sformatf("b%0d", j), base + j, j % 2,
                     ((j % 2) ? 8'hA0 : 8'h20) + 8'(32 * (j / 2)), 60);
         if (j > 0) chk($sformatf("b%0d_ifg", j), fr_gap[base + j], 12);
      end

      // port 1 underrun after 20 of 100 bytes, then a clean 30-byte frame
      do_reset();
      base = fr_len.size();
      und0 = n_und;
      er0 = n_er;
      drive_frame(1, 100, 8'h01, 20);
      drive_frame(1, 30, 8'h33, -1);
      wait_frames("c", base + 2, 400);
      chk("c0_len", fr_len[base], 8 + 20 + 1);
      chk("c0_grant", fr_grant[base], 1);
      nbad = 0;
      for (int i = 0; i < 20; i++)
         if (mb[fr_start[base] + 8 + i] !== {1'b0, 8'h01 + 8'(i)}) nbad++;
      chk("c0_bytes", nbad, 0);
      chk("c0_err_sym", mb[fr_start[base] + 28], {1'b1, 8'h00});
      chk("c_underrun_cnt", n_und - und0, 1);
      chk("c_tx_er_cnt", n_er - er0, 1);
      chk("c_drain_gap", fr_gap[base + 1], 80 + 12);
      check_frame("c1", base + 1, 1, 8'h33, 30);

      // reset during byte 30 of a port 0 frame, then port 1 restarts cleanly
      do_reset();
      fork
         drive_frame(0, 64, 8'h40, -1);
         begin
            for (int t = 0; t < 400; t++) begin
               @(negedge clk);
               if (drv_cnt[0] >= 30) break;
            end
            chk("d_reach", 32'(drv_cnt[0] >= 30), 1);
            chk("d_pre_drdy", p0_drdy, 1);
            reset = 1'b1;
            drv_kill = 1;
            #1;
            chk("d_rst_tx_en", tx_en, 0);
            chk("d_rst_p0_drdy", p0_drdy, 0);
            chk("d_rst_p1_drdy", p1_drdy, 0);
         end
      join
      repeat (2) @(negedge clk);
      reset = 1'b0;
      drv_kill = 0;
      repeat (2) @(negedge clk);
      base = fr_len.size();
      drive_frame(1, 30, 8'hC3, -1);
      wait_frames("d", base + 1, 200);
      check_frame("d1", base, 1, 8'hC3, 30);

      // IFG_LEN=1 instance, back-to-back single-byte frames on port 0
      @(posedge clk);
      #1;
      e_on = 1;
      q0_srdy = 1; q0_eop = 1; q0_data = 8'h3C;
      repeat (70) @(posedge clk);
      #1;
      q0_srdy = 0; q0_eop = 0;
      e_on = 0;
      run = 0;
      cur = 0;
      foreach (en_q[i]) begin
         if (en_q[i] == cur) run++;
         else begin
            if (cur) hi.push_back(run); else lo.push_back(run);
            cur = en_q[i];
            run = 1;
         end
      end
      chk("e_frames", 32'(hi.size() >= 4), 1);
      nbad = 0;
      for (int k = 0; k < 3 && k < hi.size(); k++) if (hi[k] != 9 + FCS) nbad++;
      chk("e_en_high_runs", nbad, 0);
      nbad = 0;
      for (int k = 1; k < 4 && k < lo.size(); k++) if (lo[k] != 1) nbad++;
      chk("e_en_low_runs", nbad, 0);
      chk("e_grant", q_grant, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
